// File: rtl/mux_arbitrado.sv
// mux_arbitrado: registered N-channel multiplexer with a valid/pronta handshake
// on every input and on the output. One channel is granted per cycle, either by
// fixed index (selecao) or by round-robin among the requesting channels. The
// chosen word lands in a one-entry output register that drains and refills on
// the same edge, so there are no bubbles while the consumer keeps up.
//
// Optional feature: define MUX_ARBITRADO_CONTADOR_EN to compile in the 32-bit
// output-transfer counter and its port `contagem`.
//
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high
//   modo            0 = fixed selection, 1 = round-robin
//   selecao         channel index for fixed mode
//   entrada_valida  per-channel valid
//   entrada_dados   channel i at [i*LARGURA +: LARGURA]
//   entrada_pronta  per-channel ready, one-hot or zero
//   saida_valida    output register holds a word
//   saida_pronta    consumer accepts the word
//   saida_dados     registered output word
//   saida_canal     source channel of saida_dados
//   contagem        output transfer count (only with the macro)

module mux_arbitrado #(
   parameter int LARGURA = 32,
   parameter int CANAIS  = 4,
   parameter int SEL_W   = $clog2(CANAIS)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       modo,
   input  logic [SEL_W-1:0]           selecao,
   input  logic [CANAIS-1:0]          entrada_valida,
   input  logic [CANAIS*LARGURA-1:0]  entrada_dados,
   output logic [CANAIS-1:0]          entrada_pronta,
   output logic                       saida_valida,
   input  logic                       saida_pronta,
   output logic [LARGURA-1:0]         saida_dados,
`ifdef MUX_ARBITRADO_CONTADOR_EN
   output logic [SEL_W-1:0]           saida_canal,
   output logic [31:0]                contagem
`else
   output logic [SEL_W-1:0]           saida_canal
`endif
);

   localparam logic [SEL_W:0]   CANAIS_L = (SEL_W+1)'(CANAIS);
   localparam logic [SEL_W-1:0] ULTIMO   = SEL_W'(CANAIS-1);

   logic [SEL_W-1:0]   ponteiro;
   logic [SEL_W-1:0]   concedido;
   logic               tem_concessao;
   logic               livre;
   logic               valida_g;
   logic [LARGURA-1:0] dados_g;
   logic               transf_entrada;
   logic               transf_saida;
   logic [SEL_W-1:0]   prox_ponteiro;

   assign livre        = !saida_valida || saida_pronta;
   assign transf_saida = saida_valida && saida_pronta;

   // Grant selection. Round-robin picks the valid channel closest to ponteiro
   // going upward with wrap; distance is computed per channel so the search
   // unrolls into plain compare logic.
   always_comb begin
      int p;
      int d;
      int melhor;
      concedido     = '0;
      tem_concessao = 1'b0;
      p             = 32'(ponteiro);
      d             = 0;
      melhor        = CANAIS;
      if (!modo) begin
         if ({1'b0, selecao} < CANAIS_L) begin
            concedido     = selecao;
            tem_concessao = 1'b1;
         end
      end else begin
         for (int i = 0; i < CANAIS; i++) begin
            d = (i >= p) ? (i - p) : (i + CANAIS - p);
            if (entrada_valida[i] && (d < melhor)) begin
               melhor        = d;
               concedido     = SEL_W'(i);
               tem_concessao = 1'b1;
            end
         end
      end
   end

   // Ready is held low during reset so nothing appears accepted on a
   // discarded cycle.
   always_comb begin
      entrada_pronta = '0;
      valida_g       = 1'b0;
      dados_g        = '0;
      for (int i = 0; i < CANAIS; i++) begin
         if (tem_concessao && (concedido == SEL_W'(i))) begin
            entrada_pronta[i] = livre && !reset;
            valida_g          = entrada_valida[i];
            dados_g           = entrada_dados[i*LARGURA +: LARGURA];
         end
      end
   end

   assign transf_entrada = tem_concessao && valida_g && livre;
   assign prox_ponteiro  = (concedido == ULTIMO) ? '0 : concedido + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         saida_valida <= 1'b0;
         saida_dados  <= '0;
         saida_canal  <= '0;
         ponteiro     <= '0;
      end else begin
         if (transf_entrada) begin
            saida_dados  <= dados_g;
            saida_canal  <= concedido;
            saida_valida <= 1'b1;
            if (modo) begin
               ponteiro <= prox_ponteiro;
            end
         end else if (transf_saida) begin
            saida_valida <= 1'b0;
         end
      end
   end

`ifdef MUX_ARBITRADO_CONTADOR_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         contagem <= '0;
      end else if (transf_saida) begin
         contagem <= contagem + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux_arbitrado.sv
module tb_mux_arbitrado;

   localparam int L  = 32;
   localparam int C  = 4;
   localparam int SW = 2;
   localparam int L3 = 8;
   localparam int C3 = 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            modo;
   logic [SW-1:0]   selecao;
   logic [C-1:0]    entrada_valida;
   logic [C*L-1:0]  entrada_dados;
   logic [C-1:0]    entrada_pronta;
   logic            saida_valida;
   logic            saida_pronta;
   logic [L-1:0]    saida_dados;
   logic [SW-1:0]   saida_canal;

   logic [SW-1:0]   selecao3;
   logic [C3-1:0]   valida3;
   logic [C3*L3-1:0] dados3;
   logic [C3-1:0]   pronta3;
   logic            saida_valida3;
   logic [L3-1:0]   saida_dados3;
   logic [SW-1:0]   saida_canal3;

`ifdef MUX_ARBITRADO_CONTADOR_EN
   logic [31:0]     contagem;
   logic [31:0]     contagem3;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mux_arbitrado #(.LARGURA(L), .CANAIS(C)) dut (
      .clock(clock), .reset(reset), .modo(modo), .selecao(selecao),
      .entrada_valida(entrada_valida), .entrada_dados(entrada_dados),
      .entrada_pronta(entrada_pronta), .saida_valida(saida_valida),
      .saida_pronta(saida_pronta), .saida_dados(saida_dados),
`ifdef MUX_ARBITRADO_CONTADOR_EN
      .saida_canal(saida_canal), .contagem(contagem)
`else
      .saida_canal(saida_canal)
`endif
   );

   mux_arbitrado #(.LARGURA(L3), .CANAIS(C3)) dut3 (
      .clock(clock), .reset(reset), .modo(modo), .selecao(selecao3),
      .entrada_valida(valida3), .entrada_dados(dados3),
      .entrada_pronta(pronta3), .saida_valida(saida_valida3),
      .saida_pronta(saida_pronta), .saida_dados(saida_dados3),
`ifdef MUX_ARBITRADO_CONTADOR_EN
      .saida_canal(saida_canal3), .contagem(contagem3)
`else
      .saida_canal(saida_canal3)
`endif
   );

   function automatic logic [L-1:0] palavra(input int ch);
      return 32'hC0DE_0000 + 32'(ch);
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic carrega_padrao;
      for (int i = 0; i < C; i++) entrada_dados[i*L +: L] = palavra(i);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      modo = 1'b1;
      selecao = 2'd0;
      entrada_valida = '1;
      entrada_dados = '1;
      saida_pronta = 1'b1;
      selecao3 = 2'd0;
      valida3 = '1;
      dados3 = '1;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if (entrada_pronta !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pronta cyc%0d got=%b exp=0000", k, entrada_pronta);
         end
      end
      reset = 1'b0;
      entrada_valida = '0;
      valida3 = '0;
      #1;
      total++;
      if (saida_valida !== 1'b0 || saida_dados !== 32'd0 || saida_canal !== 2'd0) begin
         bad++;
         $display("FAIL reset_saida got v=%b d=%h c=%0d exp 0/0/0", saida_valida, saida_dados, saida_canal);
      end
      total++;
      if (saida_valida3 !== 1'b0) begin
         bad++;
         $display("FAIL reset_saida3 got=%b exp=0", saida_valida3);
      end
   endtask

   task automatic test_fixed;
      modo = 1'b0;
      selecao = 2'd2;
      carrega_padrao();
      entrada_dados[2*L +: L] = 32'hDEAD_BEEF;
      entrada_valida = 4'b0100;
      saida_pronta = 1'b1;
      #1;
      total++;
      if (entrada_pronta !== 4'b0100) begin
         bad++;
         $display("FAIL fixo_pronta got=%b exp=0100", entrada_pronta);
      end
      tick();
      entrada_valida = 4'b0000;
      total++;
      if (saida_valida !== 1'b1 || saida_dados !== 32'hDEAD_BEEF || saida_canal !== 2'd2) begin
         bad++;
         $display("FAIL fixo_saida got v=%b d=%h c=%0d exp 1/deadbeef/2", saida_valida, saida_dados, saida_canal);
      end
      tick();
      total++;
      if (saida_valida !== 1'b0) begin
         bad++;
         $display("FAIL fixo_dreno got=%b exp=0", saida_valida);
      end
      // three-channel instance: index 3 is out of range
      selecao3 = 2'd1;
      valida3 = 3'b010;
      dados3 = 24'h33_22_11;
      tick();
      total++;
      if (saida_valida3 !== 1'b1 || saida_dados3 !== 8'h22 || saida_canal3 !== 2'd1) begin
         bad++;
         $display("FAIL fixo3_carga got v=%b d=%h c=%0d exp 1/22/1", saida_valida3, saida_dados3, saida_canal3);
      end
      selecao3 = 2'd3;
      valida3 = 3'b111;
      #1;
      total++;
      if (pronta3 !== 3'b000) begin
         bad++;
         $display("FAIL fixo3_fora_pronta got=%b exp=000", pronta3);
      end
      tick();
      total++;
      if (saida_valida3 !== 1'b0) begin
         bad++;
         $display("FAIL fixo3_fora_valida got=%b exp=0", saida_valida3);
      end
      valida3 = '0;
   endtask

   task automatic test_round_robin;
      modo = 1'b1;
      carrega_padrao();
      entrada_valida = 4'b1111;
      saida_pronta = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         total++;
         if (saida_valida !== 1'b1 || saida_canal !== SW'(k % 4) || saida_dados !== palavra(k % 4)) begin
            bad++;
            $display("FAIL rr_seq k=%0d got v=%b c=%0d d=%h exp 1/%0d/%h",
                     k, saida_valida, saida_canal, saida_dados, k % 4, palavra(k % 4));
         end
      end
   endtask

   task automatic test_skip_wrap;
      // pointer is 2 after the six round-robin grants
      entrada_valida = 4'b1010;
      #1;
      total++;
      if (entrada_pronta !== 4'b1000) begin
         bad++;
         $display("FAIL salto_pronta3 got=%b exp=1000", entrada_pronta);
      end
      tick();
      total++;
      if (saida_canal !== 2'd3) begin
         bad++;
         $display("FAIL salto_canal3 got=%0d exp=3", saida_canal);
      end
      total++;
      if (entrada_pronta !== 4'b0010) begin
         bad++;
         $display("FAIL salto_pronta1 got=%b exp=0010", entrada_pronta);
      end
      tick();
      total++;
      if (saida_canal !== 2'd1 || saida_dados !== palavra(1)) begin
         bad++;
         $display("FAIL salto_canal1 got c=%0d d=%h exp 1/%h", saida_canal, saida_dados, palavra(1));
      end
   endtask

   task automatic test_stall;
      // pointer is 2; load channel 2, then stall
      entrada_valida = 4'b1111;
      tick();
      saida_pronta = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (entrada_pronta !== 4'b0000 || saida_dados !== palavra(2) || saida_canal !== 2'd2 || saida_valida !== 1'b1) begin
            bad++;
            $display("FAIL stall k=%0d got p=%b d=%h c=%0d v=%b exp 0000/%h/2/1",
                     k, entrada_pronta, saida_dados, saida_canal, saida_valida, palavra(2));
         end
         tick();
      end
      saida_pronta = 1'b1;
      #1;
      total++;
      if (entrada_pronta !== 4'b1000) begin
         bad++;
         $display("FAIL stall_libera_pronta got=%b exp=1000", entrada_pronta);
      end
      tick();
      total++;
      if (saida_valida !== 1'b1 || saida_canal !== 2'd3 || saida_dados !== palavra(3)) begin
         bad++;
         $display("FAIL stall_libera got v=%b c=%0d d=%h exp 1/3/%h", saida_valida, saida_canal, saida_dados, palavra(3));
      end
      entrada_valida = '0;
      tick();
   endtask

   task automatic test_fixed_keeps_pointer;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      modo = 1'b0;
      selecao = 2'd1;
      entrada_valida = 4'b0010;
      tick();
      modo = 1'b1;
      entrada_valida = 4'b1111;
      #1;
      total++;
      if (entrada_pronta !== 4'b0001) begin
         bad++;
         $display("FAIL ponteiro_fixo got=%b exp=0001", entrada_pronta);
      end
      entrada_valida = '0;
      tick();
      tick();
   endtask

`ifdef MUX_ARBITRADO_CONTADOR_EN
   task automatic test_counter;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      modo = 1'b1;
      saida_pronta = 1'b1;
      entrada_valida = 4'b1111;
      for (int k = 0; k < 5; k++) tick();
      entrada_valida = '0;
      tick();
      total++;
      if (contagem !== 32'd5) begin
         bad++;
         $display("FAIL contador5 got=%0d exp=5", contagem);
      end
      entrada_valida = 4'b1111;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      entrada_valida = '0;
      total++;
      if (contagem !== 32'd0) begin
         bad++;
         $display("FAIL contador_reset got=%0d exp=0", contagem);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fixed();
      test_round_robin();
      test_skip_wrap();
      test_stall();
      test_fixed_keeps_pointer();
`ifdef MUX_ARBITRADO_CONTADOR_EN
      test_counter();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_arbitrado.md
# mux_arbitrado

- Parametrised, registered N-channel multiplexer with a valid/pronta handshake on every input and on the output.
- Selects one input channel per cycle and holds the chosen word in a one-entry output register.
- Two selection modes: fixed, where the channel index comes from `selecao`, and round-robin arbitration among the requesting channels.
- Sits between datapath producers (ALU, memory read, PC+4 sources) and a consumer stage that may stall.

## Interface
- `LARGURA`, 32: data width per channel.
- `CANAIS`, 4: number of input channels, 2..16.
- `SEL_W`, `$clog2(CANAIS)`: derived parameter, index width.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `modo`  in  1: 0 = fixed selection via `selecao`; 1 = round-robin.
- `selecao`  in  SEL_W: channel index in fixed mode; ignored in round-robin mode.
- `entrada_valida`  in  CANAIS: per-channel valid.
- `entrada_dados`  in  CANAIS*LARGURA: channel i occupies bits [i*LARGURA +: LARGURA].
- `entrada_pronta`  out  CANAIS: per-channel ready; one-hot or zero.
- `saida_valida`  out  1: output register holds a word.
- `saida_pronta`  in  1: consumer accepts the word.
- `saida_dados`  out  LARGURA: registered output word.
- `saida_canal`  out  SEL_W: source channel of `saida_dados`.
- `contagem`  out  32: present only with `MUX_ARBITRADO_CONTADOR_EN`.

## Operation
- **Free slot:** `livre = !saida_valida || saida_pronta`.
- **Grant, fixed mode:**
  - Grant channel `selecao` if `selecao < CANAIS`.
  - If `selecao >= CANAIS`, grant no channel and accept nothing.
- **Grant, round-robin mode:**
  - Grant the first channel with `entrada_valida` set, searching upward from `ponteiro` and wrapping at `CANAIS-1` to 0.
  - If no channel is valid, grant none.
- **Ready:** `entrada_pronta[g] = livre` for the granted channel `g`; all other bits are 0.
- **Transfer:** on channel g, a transfer occurs when `entrada_valida[g] && entrada_pronta[g]`. On that edge:
  - `saida_dados <= dados[g]`, `saida_canal <= g`, `saida_valida <= 1`.
  - In round-robin mode, `ponteiro <= g+1`, wrapping to 0 after `CANAIS-1`.
- **Output handshake:**
  - Output transfer when `saida_valida && saida_pronta`.
  - If no input transfer occurs on the same edge, `saida_valida <= 0`.
- **Simultaneous transfers:** an output transfer and an input transfer on the same edge load the new word. There are no bubbles.
- **Stall:** while `saida_valida && !saida_pronta`, `saida_dados` and `saida_canal` stay stable and all `entrada_pronta` bits are 0.
- **Pointer:** `ponteiro` changes only on a round-robin transfer. Fixed-mode transfers leave it unchanged.
- **Mode change:** a change of `modo` or `selecao` takes effect in the same cycle for the grant. It does not alter a word already held in the output register.
- **Reset:** reset during any state clears everything, including a held word, which is discarded.

## Timing
- **Reset values:** `saida_valida`=0, `saida_dados`=0, `saida_canal`=0, `ponteiro`=0, `contagem`=0.
- **Latency:** 1 cycle from input transfer to `saida_valida`.
- **Throughput:** 1 word per cycle when `saida_pronta` is held high.
- **Combinational paths:**
  - `entrada_pronta` depends combinationally on `modo`, `selecao`, `entrada_valida`, `ponteiro`, `saida_valida` and `saida_pronta`.
  - There is no combinational path from any input to `saida_*`.
- **Reset priority:** `reset` overrides any transfer on the same edge.

## Configuration
- **`MUX_ARBITRADO_CONTADOR_EN` defined:**
  - Port `contagem` and a 32-bit counter are compiled in.
  - The counter increments by 1 on every output transfer and wraps from 0xFFFFFFFF to 0.
  - It resets to 0.
- **Not defined:** port and counter are absent; all other behaviour is identical.

## Test plan
- **Reset:** reset high 2 cycles with all inputs active, then release → all outputs 0, `entrada_pronta`=0000 during reset.
- **Fixed mode:** `modo`=0, `selecao`=2, ch2 valid with 0xDEADBEEF, `saida_pronta`=1 → next cycle `saida_dados`=0xDEADBEEF, `saida_canal`=2. Then `selecao`=3 with CANAIS=3 → no `entrada_pronta`, `saida_valida` falls.
- **Round-robin:** `modo`=1, all 4 channels continuously valid, `saida_pronta`=1 → `saida_canal` sequence 0,1,2,3,0,1, one word per cycle.
- **Stall:** hold `saida_pronta`=0 for 3 cycles with the output full → `saida_dados` stable, `entrada_pronta`=0. Then release → the new word loads on the same edge as the output transfer.
- **Skip and wrap:** round-robin with only ch1 and ch3 valid, `ponteiro`=2 → grant 3, then 1.
- **Counter:** with the macro defined, preload via 5 transfers → `contagem`=5. Force wrap near 0xFFFFFFFF in a long run → rolls to 0. Reset mid-burst → 0.
